// File: rtl/mantissa_sub_serial.sv
// Bit-serial unsigned significand subtractor producing |a-b| plus sign/zero flags.
// Latency WIDTH+1 cycles (b<=a) or 2*WIDTH+1 (b>a); start is ignored while busy.
module mantissa_sub_serial #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             swap,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic             borrow;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full-subtractor on the current LSBs, and invert-plus-carry for negation.
  logic sub_bit;
  logic sub_borrow;
  logic neg_bit;
  logic neg_carry;

  assign sub_bit    = opa[0] ^ opb[0] ^ borrow;
  assign sub_borrow = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & borrow);
  assign neg_bit    = ~work[0] ^ carry;
  assign neg_carry  = ~work[0] & carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      work   <= '0;
      borrow <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      swap   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa    <= a;
            opb    <= b;
            work   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SUB;
          end
        end

        SUB: begin
          opa    <= opa >> 1;
          opb    <= opb >> 1;
          work   <= {sub_bit, work[WIDTH-1:1]};
          borrow <= sub_borrow;
          if (cnt == LAST) begin
            cnt   <= '0;
            carry <= 1'b1;
            state <= sub_borrow ? NEG : DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Rotating the working register through a full pass leaves every bit back in place.
        NEG: begin
          work  <= {neg_bit, work[WIDTH-1:1]};
          carry <= neg_carry;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          diff  <= work;
          swap  <= borrow;
          zero  <= (work == '0);
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_sub_serial.sv
// Bench for mantissa_sub_serial: arithmetic reference model checked every cycle,
// plus directed operand cases with hand-computed results and latencies.
module tb_mantissa_sub_serial;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         swap;
  logic         zero;

  int ncmp = 0;
  int nmis = 0;
  int cyc  = 0;

  mantissa_sub_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .swap (swap),
    .zero (zero)
  );

  always #5 clk = ~clk;

  // Reference model: what the outputs must be after each rising edge.
  bit           mvalid = 1'b0;
  bit           pending = 1'b0;
  int           done_at = 0;
  logic [W-1:0] p_diff;
  logic         p_swap;
  logic         p_zero;
  logic         e_busy, e_done, e_swap, e_zero;
  logic [W-1:0] e_diff;

  always @(posedge clk) begin
    cyc++;
    e_done = 1'b0;
    if (rst) begin
      mvalid  = 1'b1;
      pending = 1'b0;
      e_busy  = 1'b0;
      e_diff  = '0;
      e_swap  = 1'b0;
      e_zero  = 1'b0;
    end else if (mvalid) begin
      if (pending) begin
        if (cyc == done_at) begin
          pending = 1'b0;
          e_busy  = 1'b0;
          e_done  = 1'b1;
          e_diff  = p_diff;
          e_swap  = p_swap;
          e_zero  = p_zero;
        end
      end else if (start) begin
        pending = 1'b1;
        e_busy  = 1'b1;
        p_swap  = (b > a);
        p_diff  = p_swap ? (b - a) : (a - b);
        p_zero  = (a == b);
        done_at = cyc + (p_swap ? 2 * W + 1 : W + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      ncmp++;
      if ({busy, done, swap, zero, diff} !== {e_busy, e_done, e_swap, e_zero, e_diff}) begin
        nmis++;
        $display("FAIL cycle_model cyc=%0d got busy=%b done=%b swap=%b zero=%b diff=%h expected busy=%b done=%b swap=%b zero=%b diff=%h",
                 cyc, busy, done, swap, zero, diff, e_busy, e_done, e_swap, e_zero, e_diff);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat is cycles from accept edge, -1 on timeout.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, output int lat);
    int c0;
    start = 1'b1;
    a     = ta;
    b     = tb;
    @(negedge clk);
    start = 1'b0;
    c0    = cyc;
    lat   = -1;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [W-1:0] ra, rb;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(11'h400, 11'h001, lat);
    check("op1_lat", 32'(lat), 32'd12);
    check("op1_diff", 32'(diff), 32'h3FF);
    check("op1_flags", {30'd0, swap, zero}, 32'd0);

    do_op(11'h005, 11'h009, lat);
    check("op2_lat", 32'(lat), 32'd23);
    check("op2_diff", 32'(diff), 32'h004);
    check("op2_flags", {30'd0, swap, zero}, 32'd2);

    do_op(11'h7FF, 11'h7FF, lat);
    check("op3_lat", 32'(lat), 32'd12);
    check("op3_diff", 32'(diff), 32'h000);
    check("op3_flags", {30'd0, swap, zero}, 32'd1);

    // Start pulsed mid-operation must be ignored.
    start = 1'b1;
    a     = 11'h000;
    b     = 11'h7FF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 11'h001;
    b     = 11'h000;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("op4_diff", 32'(diff), 32'h7FF);
    check("op4_flags", {30'd0, swap, zero}, 32'd2);

    // Reset five cycles into an operation aborts it without a done pulse.
    start = 1'b1;
    a     = 11'h123;
    b     = 11'h045;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_flags", {30'd0, swap, zero}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("abort_ndone", 32'(ndone), 32'd0);
    do_op(11'h123, 11'h045, lat);
    check("post_abort_lat", 32'(lat), 32'd12);
    check("post_abort_diff", 32'(diff), 32'h0DE);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 2047));
      rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom_range(0, 2047));
      do_op(ra, rb, lat);
      check("rand_lat", 32'(lat), (rb > ra) ? 32'd23 : 32'd12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/mantissa_sub_serial.md
MANTISSA_SUB_SERIAL -- requirements
Module: mantissa_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 11, the operand and result width in bits (FP16 significand including hidden bit).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-009 SHALL have port diff  output  WIDTH  magnitude |a-b|.
REQ-010 SHALL have port swap  output  1  high when b > a, so the result sign is inverted.
REQ-011 SHALL have port zero  output  1  high when a == b.

Function
REQ-012 SHALL implement states IDLE, SUB, NEG, DONE; all outputs registered.
REQ-013 SHALL, in IDLE with start=1, latch a and b, clear borrow and the bit counter, and enter SUB on that edge (the accept edge).
REQ-014 SHALL, in SUB, process one bit per cycle, LSB first, with a 1-bit full-subtractor: d = a_i ^ b_i ^ borrow; borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
REQ-015 SHALL shift each difference bit into a WIDTH-bit result register from the MSB end, so after WIDTH SUB cycles bit i sits at position i.
REQ-016 SHALL stay in SUB for exactly WIDTH cycles, then enter NEG if the final borrow=1, else DONE.
REQ-017 SHALL, in NEG, two's-complement the result bit-serially, LSB first: invert each bit and add a carry initialised to 1; it SHALL take exactly WIDTH cycles, then enter DONE.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle, update swap to the final borrow and zero to (result==0), then return to IDLE.
REQ-019 SHALL hold diff, swap and zero stable from DONE until the next DONE; they SHALL NOT change during SUB or NEG, since the internal working register is separate from diff.
REQ-020 SHALL give latency from the accept edge to the done=1 cycle of WIDTH+1 cycles when b <= a and 2*WIDTH+1 cycles when b > a.
REQ-021 SHALL ignore start while busy=1; operands SHALL NOT be re-latched.
REQ-022 SHALL NOT accept a new start in the DONE cycle; start is accepted at earliest in the following IDLE cycle.
REQ-023 SHALL treat operands as unsigned; a=0 with b=2^WIDTH-1 SHALL yield diff=2^WIDTH-1 and swap=1, with no overflow case.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state=IDLE, busy=0, done=0, diff=0, swap=0, zero=0, and clear borrow, counter and working registers.
REQ-025 SHALL let rst take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.

Verification
REQ-026 SHALL cover a=0x400, b=0x001 -> done 12 cycles after accept, diff=0x3FF, swap=0, zero=0.
REQ-027 SHALL cover a=0x005, b=0x009 -> done 23 cycles after accept, diff=0x004, swap=1, zero=0.
REQ-028 SHALL cover a=b=0x7FF -> done 12 cycles after accept, diff=0x000, swap=0, zero=1.
REQ-029 SHALL cover a=0x000, b=0x7FF -> diff=0x7FF, swap=1; then start pulsed with a=1, b=0 while busy -> ignored, exactly one done, results unchanged.
REQ-030 SHALL cover rst asserted 5 cycles after accept -> next cycle busy=0 and diff/swap/zero=0, no done; a new start then completes normally.
REQ-031 SHALL run a random self-check of 1000 operand pairs against a reference model: |a-b|, b>a, a==b, and the REQ-020 latency.
